// File: rtl/ram_req_rsp_if.sv
//------------------------------------------------------------------------------
// Module      : ram_req_rsp_if
// Description : Request / response bundle for the ram_req_rsp storage block.
//               The master issues valid/ready requests and consumes buffered
//               read responses. The slave is the RAM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ram_req_rsp_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_we;
   logic [ADDR_WIDTH-1:0]     req_addr;
   logic [DATA_WIDTH-1:0]     req_wdata;
   logic [DATA_WIDTH/8-1:0]   req_be;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [DATA_WIDTH-1:0]     rsp_rdata;
   logic                      busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, busy
   );
endinterface

`default_nettype wire

// File: rtl/ram_req_rsp.sv
//------------------------------------------------------------------------------
// Module      : ram_req_rsp
// Description : Single-port synchronous RAM with a valid/ready request channel,
//               per-byte write enables, optional read-data pipeline stage,
//               a buffered in-order read-response FIFO and a post-reset
//               zeroing sweep.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_req_rsp #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int LENGTH         = 1 << ADDR_WIDTH,
   parameter int OUT_REG        = 0,
   parameter int RSP_DEPTH      = 2,
   parameter int CLEAR_ON_RESET = 1
) (
   input  wire logic       clk,
   input  wire logic       rst,
   ram_req_rsp_if.slave    bus
);

   localparam int c_NB = DATA_WIDTH / 8;
   localparam int c_IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam int c_PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int c_CW = $clog2(RSP_DEPTH + 1);

   // LENGTH may equal 2**ADDR_WIDTH, so the range compare needs one extra bit
   localparam logic [ADDR_WIDTH:0] c_LEN       = (ADDR_WIDTH + 1)'(LENGTH);
   localparam logic [c_IW-1:0]     c_CLR_LAST  = c_IW'(LENGTH - 1);
   localparam logic [c_CW-1:0]     c_DEPTH     = c_CW'(RSP_DEPTH);
   localparam logic [c_PW-1:0]     c_PTR_LAST  = c_PW'(RSP_DEPTH - 1);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   // Storage and control state
   logic [DATA_WIDTH-1:0] r_mem [0:LENGTH-1];
   state_t                r_state;
   logic [c_IW-1:0]       r_clr_addr;
   logic                  r_busy;
   logic                  r_req_ready;
   logic [c_CW-1:0]       r_count;

   // First read stage: sampled array word
   logic                  r_s1_vld;
   logic [DATA_WIDTH-1:0] r_s1_data;

   // Response FIFO
   logic [DATA_WIDTH-1:0] r_fifo [0:RSP_DEPTH-1];
   logic [c_PW-1:0]       r_wr_ptr;
   logic [c_PW-1:0]       r_rd_ptr;
   logic [c_CW-1:0]       r_fifo_cnt;

   logic                  w_in_range;
   logic [c_IW-1:0]       w_idx;
   logic                  w_req_acc;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic                  w_fifo_empty;
   logic                  w_pop;
   logic                  w_push;
   logic [DATA_WIDTH-1:0] w_push_data;
   logic [c_CW-1:0]       w_count_nxt;

   assign w_in_range   = ({1'b0, bus.req_addr} < c_LEN);
   assign w_idx        = bus.req_addr[c_IW-1:0];
   assign w_req_acc    = bus.req_valid & r_req_ready;
   assign w_rd_acc     = w_req_acc & ~bus.req_we;
   assign w_wr_acc     = w_req_acc & bus.req_we & w_in_range;
   assign w_fifo_empty = (r_fifo_cnt == '0);
   assign w_pop        = ~w_fifo_empty & bus.rsp_ready;

   function automatic logic [c_PW-1:0] f_ptr_inc(input logic [c_PW-1:0] p);
      if (p == c_PTR_LAST) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // Outstanding reads: accepted but not yet popped by the consumer
   always_comb begin
      w_count_nxt = r_count;
      if (w_rd_acc && !w_pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (!w_rd_acc && w_pop) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   // Control FSM: clear sweep after reset, then request service with
   // req_ready registered from the next outstanding count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
         r_clr_addr  <= '0;
         r_busy      <= (CLEAR_ON_RESET != 0);
         r_req_ready <= (CLEAR_ON_RESET == 0);
         r_count     <= '0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_clr_addr <= r_clr_addr + 1'b1;
               if (r_clr_addr == c_CLR_LAST) begin
                  r_state     <= S_RUN;
                  r_busy      <= 1'b0;
                  r_req_ready <= 1'b1;
               end
            end
            S_RUN: begin
               r_count     <= w_count_nxt;
               r_req_ready <= (w_count_nxt < c_DEPTH);
            end
            default: begin
               r_state     <= S_RUN;
               r_busy      <= 1'b0;
               r_req_ready <= 1'b0;
            end
         endcase
      end
   end

   // Array writes: zeroing sweep, or byte-masked request writes in range
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == S_CLEAR) begin
            r_mem[r_clr_addr] <= '0;
         end else if (w_wr_acc) begin
            for (int b = 0; b < c_NB; b++) begin
               if (bus.req_be[b]) begin
                  r_mem[w_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
               end
            end
         end
      end
   end

   // Read sample at the accept edge; out-of-range reads yield zero
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
      end else begin
         r_s1_vld <= w_rd_acc;
      end
      if (w_rd_acc) begin
         r_s1_data <= w_in_range ? r_mem[w_idx] : '0;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                  r_s2_vld;
         logic [DATA_WIDTH-1:0] r_s2_data;

         // Extra pipeline stage between the array and the response FIFO
         always_ff @(posedge clk) begin
            if (rst) begin
               r_s2_vld <= 1'b0;
            end else begin
               r_s2_vld <= r_s1_vld;
            end
            if (r_s1_vld) begin
               r_s2_data <= r_s1_data;
            end
         end

         assign w_push      = r_s2_vld;
         assign w_push_data = r_s2_data;
      end else begin : g_no_out_reg
         assign w_push      = r_s1_vld;
         assign w_push_data = r_s1_data;
      end
   endgenerate

   // Response FIFO; cannot overflow because r_count bounds all reads in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_data;
            r_wr_ptr         <= f_ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.busy      = r_busy;
   assign bus.rsp_valid = ~w_fifo_empty;
   // Zero while empty so the output is defined straight out of reset
   assign bus.rsp_rdata = w_fifo_empty ? '0 : r_fifo[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_ram_req_rsp.sv
//------------------------------------------------------------------------------
// Module      : tb_ram_req_rsp
// Description : Directed bench for ram_req_rsp. Instance A clears on reset
//               with no output stage; instance B keeps memory over reset and
//               adds the output stage. Both share one request driver; the
//               instance not under test is parked in reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ram_req_rsp;

   localparam int AW  = 12;
   localparam int DW  = 32;
   localparam int LEN = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_a;
   logic          rst_b;
   logic          sel;
   logic          t_valid;
   logic          t_we;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_wdata;
   logic [3:0]    t_be;
   logic          t_rsp_ready;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [DW-1:0] q_a[$];
   logic [DW-1:0] q_b[$];

   ram_req_rsp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a_if();
   ram_req_rsp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_if();

   assign a_if.req_valid = t_valid;
   assign a_if.req_we    = t_we;
   assign a_if.req_addr  = t_addr;
   assign a_if.req_wdata = t_wdata;
   assign a_if.req_be    = t_be;
   assign a_if.rsp_ready = t_rsp_ready;
   assign b_if.req_valid = t_valid;
   assign b_if.req_we    = t_we;
   assign b_if.req_addr  = t_addr;
   assign b_if.req_wdata = t_wdata;
   assign b_if.req_be    = t_be;
   assign b_if.rsp_ready = t_rsp_ready;

   ram_req_rsp #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LENGTH(LEN),
      .OUT_REG(0), .RSP_DEPTH(2), .CLEAR_ON_RESET(1)
   ) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (a_if)
   );

   ram_req_rsp #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LENGTH(LEN),
      .OUT_REG(1), .RSP_DEPTH(2), .CLEAR_ON_RESET(0)
   ) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (b_if)
   );

   logic w_ready;
   logic w_rsp_valid;
   assign w_ready     = sel ? b_if.req_ready : a_if.req_ready;
   assign w_rsp_valid = sel ? b_if.rsp_valid : a_if.rsp_valid;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Response monitors: a handshake seen at negedge completes on the next posedge
   always @(negedge clk) begin
      if (a_if.rsp_valid === 1'b1 && t_rsp_ready === 1'b1) begin
         n_cmp++;
         assert (q_a.size() != 0) else begin
            n_fail++;
            $error("FAIL a_rsp_unexpected: observed %h expected no response", a_if.rsp_rdata);
         end
         if (q_a.size() != 0) chk("a_rsp_data", a_if.rsp_rdata, q_a.pop_front());
      end
   end

   always @(negedge clk) begin
      if (b_if.rsp_valid === 1'b1 && t_rsp_ready === 1'b1) begin
         n_cmp++;
         assert (q_b.size() != 0) else begin
            n_fail++;
            $error("FAIL b_rsp_unexpected: observed %h expected no response", b_if.rsp_rdata);
         end
         if (q_b.size() != 0) chk("b_rsp_data", b_if.rsp_rdata, q_b.pop_front());
      end
   end

   // Issue one request; reads push their expected data at the accept edge
   task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [3:0] be, input logic [DW-1:0] exp);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      t_valid = 1'b1; t_we = we; t_addr = addr; t_wdata = wd; t_be = be;
      while (!acc && n < 50) begin
         acc = (w_ready === 1'b1);
         tick();
         n++;
      end
      t_valid = 1'b0;
      t_we    = 1'b0;
      chkb("req_accept", acc, 1'b1);
      if (acc && !we) begin
         if (sel) q_b.push_back(exp);
         else     q_a.push_back(exp);
      end
   endtask

   task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] wd, input logic [3:0] be);
      do_req(1'b1, addr, wd, be, 32'h0);
   endtask

   task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
      do_req(1'b0, addr, 32'h0, 4'h0, exp);
   endtask

   task automatic qsize(output int s);
      s = sel ? q_b.size() : q_a.size();
   endtask

   task automatic drain();
      int n;
      int s;
      n = 0;
      qsize(s);
      while (s != 0 && n < 50) begin
         tick();
         n++;
         qsize(s);
      end
      chk("drain_queue_empty", 32'(s), 32'd0);
   endtask

   // Cycles from accept edge until rsp_valid is seen
   task automatic rd_lat(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input int lat);
      int k;
      rd(addr, exp);
      k = 0;
      while (w_rsp_valid !== 1'b1 && k < 10) begin
         tick();
         k++;
      end
      chk("read_latency", 32'(k), 32'(lat));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n;
      logic bad_ready;
      sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
      t_valid = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t_be = '0;
      t_rsp_ready = 1'b1;
      tick();
      tick();

      // Reset state of the clearing instance
      chkb("a_rst_busy",      a_if.busy,      1'b1);
      chkb("a_rst_req_ready", a_if.req_ready, 1'b0);
      chkb("a_rst_rsp_valid", a_if.rsp_valid, 1'b0);
      chk ("a_rst_rsp_rdata", a_if.rsp_rdata, 32'h0);

      // Clear sweep: busy and not ready for exactly LEN cycles
      rst_a = 1'b0;
      n = 0;
      bad_ready = 1'b0;
      while (a_if.busy === 1'b1 && n < 100) begin
         if (a_if.req_ready !== 1'b0) bad_ready = 1'b1;
         n++;
         tick();
      end
      chk ("a_clear_cycles",      32'(n),         32'd16);
      chkb("a_clear_ready_low",   bad_ready,      1'b0);
      chkb("a_ready_after_clear", a_if.req_ready, 1'b1);
      for (int i = 0; i < LEN; i++) rd(AW'(i), 32'h0);
      drain();

      // Byte enables, including an all-zero mask
      wr(12'd5, 32'hDEADBEEF, 4'hF);
      wr(12'd5, 32'h11223344, 4'b0101);
      rd(12'd5, 32'hDE22BE44);
      wr(12'd5, 32'hFFFFFFFF, 4'h0);
      rd(12'd5, 32'hDE22BE44);
      drain();

      // Latency without output stage, then in-order back-to-back reads
      wr(12'd1, 32'h11110001, 4'hF);
      wr(12'd2, 32'h22220002, 4'hF);
      wr(12'd3, 32'h33330003, 4'hF);
      drain();
      rd_lat(12'd5, 32'hDE22BE44, 1);
      rd(12'd1, 32'h11110001);
      rd(12'd2, 32'h22220002);
      rd(12'd3, 32'h33330003);
      drain();

      // Backpressure: two reads fill the budget, the third waits
      t_rsp_ready = 1'b0;
      rd(12'd1, 32'h11110001);
      rd(12'd2, 32'h22220002);
      t_valid = 1'b1; t_we = 1'b0; t_addr = 12'd3;
      for (int i = 0; i < 4; i++) begin
         chkb("a_stall_req_ready", a_if.req_ready, 1'b0);
         chkb("a_stall_rsp_valid", a_if.rsp_valid, 1'b1);
         chk ("a_stall_rsp_rdata", a_if.rsp_rdata, q_a[0]);
         tick();
      end
      t_rsp_ready = 1'b1;
      tick();
      t_rsp_ready = 1'b0;
      chkb("a_ready_after_pop", a_if.req_ready, 1'b1);
      chk ("a_head_after_pop",  a_if.rsp_rdata, q_a[0]);
      q_a.push_back(32'h33330003);
      tick();
      t_valid = 1'b0;
      t_rsp_ready = 1'b1;
      drain();

      // Read right after write; out-of-range accesses
      wr(12'd7, 32'hA5A5A5A5, 4'hF);
      rd(12'd7, 32'hA5A5A5A5);
      wr(12'd20, 32'h12345678, 4'hF);
      rd(12'd20, 32'h0);
      rd(12'd4, 32'h0);
      rd(12'hFFF, 32'h0);
      drain();

      // Switch to the retaining instance with the output stage
      sel = 1'b1;
      rst_a = 1'b1;
      tick();
      chkb("b_rst_busy",      b_if.busy,      1'b0);
      chkb("b_rst_req_ready", b_if.req_ready, 1'b1);
      chkb("b_rst_rsp_valid", b_if.rsp_valid, 1'b0);
      rst_b = 1'b0;
      wr(12'd3, 32'hCAFEF00D, 4'hF);
      wr(12'd9, 32'h01020304, 4'hF);
      rd_lat(12'd3, 32'hCAFEF00D, 2);
      drain();

      // Reset with two reads outstanding: no responses survive
      t_rsp_ready = 1'b0;
      rd(12'd9, 32'h01020304);
      rd(12'd3, 32'hCAFEF00D);
      rst_b = 1'b1;
      tick();
      q_b.delete();
      rst_b = 1'b0;
      t_rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chkb("b_post_rst_rsp_valid", b_if.rsp_valid, 1'b0);
         tick();
      end
      rd(12'd9, 32'h01020304);
      rd(12'd3, 32'hCAFEF00D);
      drain();

      chk("a_queue_final", 32'(q_a.size()), 32'd0);
      chk("b_queue_final", 32'(q_b.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
